// File: rtl/seq_add_ctrl_if.sv
// rtl/seq_add_ctrl_if.sv - request/result bundle for seq_add_ctrl
// The op signal exists only when SEQ_ADD_SUB_EN is defined.
interface seq_add_ctrl_if #(
  parameter int NIBBLES = 4
);
  localparam int W = 4 * NIBBLES;

  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
`ifdef SEQ_ADD_SUB_EN
  logic         op;
`endif
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         busy;
  logic         done;

  modport master (
`ifdef SEQ_ADD_SUB_EN
    output op,
`endif
    output start, a, b, cin,
    input  sum, cout, ovf, busy, done
  );

  modport slave (
`ifdef SEQ_ADD_SUB_EN
    input  op,
`endif
    input  start, a, b, cin,
    output sum, cout, ovf, busy, done
  );
endinterface

// File: rtl/seq_add_ctrl.sv
// rtl/seq_add_ctrl.sv - nibble-serial adder reusing one 4-bit slice per cycle
// Define SEQ_ADD_SUB_EN to add the op input (op=1 computes a - b).
module seq_add_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic           clk,
  input  logic           rst,
  seq_add_ctrl_if.slave  bus
);
  localparam int W  = 4 * NIBBLES;
  localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          carry_q, carry_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  sum_q, sum_d;
  logic          cout_q, cout_d;
  logic          ovf_q, ovf_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
`ifdef SEQ_ADD_SUB_EN
  logic          op_q, op_d;
`endif

  logic [3:0] a_nib, b_nib, lo, slice_sum;
  logic [1:0] hi;
  logic       c3, slice_cout;

  // Slice split at bit 3 so the carry into the nibble MSB is available for ovf.
  always_comb begin
    a_nib = a_q[{cnt_q, 2'b00} +: 4];
    b_nib = b_q[{cnt_q, 2'b00} +: 4];
`ifdef SEQ_ADD_SUB_EN
    if (op_q) b_nib = ~b_nib;
`endif
    lo         = {1'b0, a_nib[2:0]} + {1'b0, b_nib[2:0]} + {3'b000, carry_q};
    c3         = lo[3];
    hi         = {1'b0, a_nib[3]} + {1'b0, b_nib[3]} + {1'b0, c3};
    slice_sum  = {hi[0], lo[2:0]};
    slice_cout = hi[1];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
`ifdef SEQ_ADD_SUB_EN
    op_d    = op_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (bus.start) begin
          state_d = RUN;
          a_d     = bus.a;
          b_d     = bus.b;
          carry_d = bus.cin;
`ifdef SEQ_ADD_SUB_EN
          op_d    = bus.op;
          if (bus.op) carry_d = 1'b1;
`endif
          sum_d   = '0;
          cout_d  = 1'b0;
          ovf_d   = 1'b0;
          cnt_d   = '0;
        end
      end
      RUN: begin
        sum_d[{cnt_q, 2'b00} +: 4] = slice_sum;
        carry_d = slice_cout;
        if (cnt_q == LAST) begin
          state_d = DONE;
          cnt_d   = '0;
          cout_d  = slice_cout;
          ovf_d   = c3 ^ slice_cout;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SEQ_ADD_SUB_EN
      op_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef SEQ_ADD_SUB_EN
      op_q    <= op_d;
`endif
    end
  end

  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
endmodule

// File: tb/tb_seq_add_ctrl.sv
// tb/tb_seq_add_ctrl.sv - scoreboard bench for seq_add_ctrl
module tb_seq_add_ctrl;
  localparam int N = 4;
  localparam int W = 4 * N;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seq_add_ctrl_if #(.NIBBLES(N)) bus ();
  seq_add_ctrl #(.NIBBLES(N)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    int           done_edge;
  } exp_t;

  exp_t         sb[$];
  exp_t         pending;
  int           n_cmp = 0;
  int           n_bad = 0;
  int           edge_n = 0;
  int           run_start = -1;
  int           run_end = -1;
  logic         exp_busy = 1'b0;
  logic [W-1:0] last_sum = '0;
  logic         last_cout = 1'b0;
  logic         last_ovf = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at edge %0d", name, act, exp, edge_n);
    end
  endtask

  // Drive one cycle of inputs, let the edge sample them, then advance the model.
  task automatic tick(input logic st, input logic [W-1:0] av, input logic [W-1:0] bv,
                      input logic ci, input logic opv, input logic r);
    logic         eff_op;
    logic [W-1:0] bop;
    logic [W:0]   full;
    exp_t         x;
    eff_op = opv;
`ifndef SEQ_ADD_SUB_EN
    eff_op = 1'b0;
`endif
    rst       = r;
    bus.start = st;
    bus.a     = av;
    bus.b     = bv;
    bus.cin   = ci;
`ifdef SEQ_ADD_SUB_EN
    bus.op    = opv;
`endif
    @(posedge clk);
    edge_n++;
    if (r) begin
      if (edge_n <= run_end && sb.size() > 0) void'(sb.pop_back());
      run_start = -1;
      run_end   = -1;
      last_sum  = '0;
      last_cout = 1'b0;
      last_ovf  = 1'b0;
      exp_busy  = 1'b0;
    end else begin
      if (edge_n == run_end) begin
        last_sum  = pending.sum;
        last_cout = pending.cout;
        last_ovf  = pending.ovf;
      end
      if (st && edge_n > run_end) begin
        bop  = eff_op ? ~bv : bv;
        full = {1'b0, av} + {1'b0, bop} + {{W{1'b0}}, (eff_op ? 1'b1 : ci)};
        x.sum       = full[W-1:0];
        x.cout      = full[W];
        x.ovf       = (av[W-1] == bop[W-1]) && (full[W-1] != av[W-1]);
        x.done_edge = edge_n + N;
        sb.push_back(x);
        pending   = x;
        run_start = edge_n;
        run_end   = edge_n + N;
      end
      exp_busy = (run_start >= 0) && (edge_n >= run_start) && (edge_n < run_end);
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), 1'b0);
  endtask

  exp_t e;
  always @(negedge clk) begin
    if (edge_n > 0) begin
      chk("busy", 64'(bus.busy), 64'(exp_busy));
      if (bus.done === 1'b1) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL spurious_done: got done=1 expected no pending result at edge %0d", edge_n);
        end else begin
          e = sb.pop_front();
          chk("sum", 64'(bus.sum), 64'(e.sum));
          chk("cout", 64'(bus.cout), 64'(e.cout));
          chk("ovf", 64'(bus.ovf), 64'(e.ovf));
          chk("done_edge", 64'(edge_n), 64'(e.done_edge));
        end
      end else begin
        chk("done", 64'(bus.done), 64'(0));
        if (sb.size() > 0 && sb[0].done_edge <= edge_n) begin
          n_cmp++;
          n_bad++;
          $display("FAIL missing_done: got no done expected done at edge %0d", sb[0].done_edge);
          void'(sb.pop_front());
        end
        if (!exp_busy) begin
          chk("hold_sum", 64'(bus.sum), 64'(last_sum));
          chk("hold_cout", 64'(bus.cout), 64'(last_cout));
          chk("hold_ovf", 64'(bus.ovf), 64'(last_ovf));
        end
      end
    end
  end

  initial begin
    tick(1'b1, 16'h1111, 16'h2222, 1'b0, 1'b0, 1'b1);
    tick(1'b1, 16'h1111, 16'h2222, 1'b0, 1'b0, 1'b1);
    tick(1'b1, 16'h1234, 16'h4321, 1'b0, 1'b0, 1'b0);
    idle(6);
    tick(1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0);
    idle(5);
    tick(1'b1, 16'h7FFF, 16'h0000, 1'b1, 1'b0, 1'b0);
    idle(5);
    tick(1'b1, 16'h0001, 16'h0001, 1'b0, 1'b0, 1'b0);
    idle(1);
    tick(1'b1, 16'hAAAA, 16'h5555, 1'b1, 1'b0, 1'b0);
    idle(5);
    tick(1'b1, 16'h1234, 16'h1111, 1'b0, 1'b0, 1'b0);
    idle(1);
    tick(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1);
    idle(1);
    tick(1'b1, 16'h00F0, 16'h0010, 1'b0, 1'b0, 1'b0);
    idle(5);
    for (int i = 0; i < N + 2; i++) tick(1'b1, W'($urandom), W'($urandom), 1'($urandom), 1'b0, 1'b0);
    idle(6);
`ifdef SEQ_ADD_SUB_EN
    tick(1'b1, 16'h0005, 16'h0007, 1'b0, 1'b1, 1'b0);
    idle(5);
    tick(1'b1, 16'h8000, 16'h0001, 1'b1, 1'b1, 1'b0);
    idle(5);
`endif
    for (int i = 0; i < 400; i++)
      tick($urandom_range(0, 2) == 0, W'($urandom), W'($urandom), 1'($urandom), 1'($urandom),
           $urandom_range(0, 39) == 0);
    idle(N + 3);
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d results outstanding expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/seq_add_ctrl.md
SEQ_ADD_CTRL -- requirements
Module: seq_add_ctrl

Interface
REQ-001 Parameter NIBBLES, default 4, number of 4-bit slices per operand; W = 4*NIBBLES; legal range 2..8.
REQ-002 Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 start  input  1  request a new addition; sampled on the rising edge of clk.
REQ-006 a  input  W  first operand; captured when start is accepted.
REQ-007 b  input  W  second operand; captured when start is accepted.
REQ-008 cin  input  1  carry-in to nibble 0; captured when start is accepted.
REQ-009 sum  output  W  result register.
REQ-010 cout  output  1  carry out of nibble NIBBLES-1.
REQ-011 ovf  output  1  two's-complement overflow (carry into MSB XOR carry out of MSB).
REQ-012 busy  output  1  high while slices are being processed.
REQ-013 done  output  1  one-cycle pulse; sum, cout and ovf are valid.

Function
REQ-014 The block SHALL contain exactly one 4-bit ripple-carry adder slice, reused once per cycle for every nibble.
REQ-015 The FSM SHALL have three states, IDLE, RUN and DONE, encoded in 2 bits.
REQ-016 start SHALL be accepted only when busy=0, i.e. in IDLE or DONE.
- On acceptance the block SHALL latch a, b and cin, clear sum, cout and ovf, set the nibble counter to 0 and go to RUN.
REQ-017 In RUN, each cycle SHALL process nibble k = counter:
- the slice adds a[4k+3:4k] + b[4k+3:4k] + carry_reg;
- the slice sum is written to sum[4k+3:4k];
- carry_reg takes the slice carry-out;
- the counter increments.
REQ-018 carry_reg SHALL equal the latched cin when nibble 0 is processed.
REQ-019 After nibble NIBBLES-1 the FSM SHALL go to DONE.
- In that same edge, cout is loaded with the final carry and ovf with (carry into bit W-1) XOR (final carry).
REQ-020 DONE SHALL last exactly one cycle with done=1.
- Next state is IDLE, or RUN if start=1 in that cycle (back-to-back operation).
REQ-021 Latency: if start is sampled high at edge t0, done SHALL be high in the cycle following edge t0+NIBBLES, i.e. NIBBLES+1 cycles after start.
REQ-022 busy SHALL be 1 exactly while in RUN.
REQ-023 start asserted while busy=1 SHALL be ignored, with no effect on the latched operands or the result.
REQ-024 Changes on a, b or cin after acceptance SHALL have no effect on the operation in progress.
REQ-025 sum, cout and ovf SHALL hold their values from DONE until the next accepted start.
- sum is not guaranteed meaningful during RUN.
REQ-026 The counter SHALL be $clog2(NIBBLES) bits wide (minimum 1) and SHALL never exceed NIBBLES-1.

Reset
REQ-027 When rst=1 at a clock edge, the block SHALL go to IDLE and clear the counter, carry_reg, latched operands, sum, cout, ovf, busy and done to 0.
REQ-028 Reset SHALL take priority over start.
REQ-029 Reset during RUN SHALL abort the operation with no done pulse.
REQ-030 The first start SHALL be accepted at the first edge with rst=0.

Configuration
REQ-031 Macro SEQ_ADD_SUB_EN controls subtraction support.
- When defined: an extra input `op` (1 bit) is latched with the operands. op=1 computes a - b by feeding ~b to the slice with nibble-0 carry forced to 1, ignoring cin; cout=1 means no borrow. op=0 is identical to the undefined case.
- When undefined: the `op` port is absent and only addition is supported.

Verification
REQ-032 NIBBLES=4: a=0x1234, b=0x4321, cin=0 -> sum=0x5555, cout=0, ovf=0; done exactly 5 cycles after start; busy high for 4 cycles.
REQ-033 a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0; a=0x7FFF, b=0x0000, cin=1 -> sum=0x8000, cout=0, ovf=1.
REQ-034 Start 0x0001+0x0001, then pulse start with a=0xAAAA two cycles later while busy -> sum=0x0002; the second start is ignored and there is one done pulse.
REQ-035 Assert rst for one cycle during the 2nd RUN cycle -> all outputs 0 next cycle, no done pulse; a following start 0x00F0+0x0010 yields 0x0100.
REQ-036 Start held high through DONE -> the second operation begins the cycle after done, and done pulses again 5 cycles later with the new result.
REQ-037 With SEQ_ADD_SUB_EN defined: op=1, a=0x0005, b=0x0007 -> sum=0xFFFE, cout=0, ovf=0; op=1, a=0x8000, b=0x0001 -> sum=0x7FFF, cout=1, ovf=1.
